// File: rtl/reg_bus_sequencer.sv
// Single-bus register sequencer: each command runs LOADY -> EXEC -> WRITE over one shared bus.
// Define REG_SEQ_R0_ZERO_EN to hardwire R0 to zero on every read and discard all writes to it.
module reg_bus_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREGS = 16,
  localparam int unsigned AW = $clog2(NREGS),
  localparam int unsigned SW = $clog2(WIDTH)
) (
  input  logic             clock_i,
  input  logic             clear_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [3:0]       cmd_op_i,
  input  logic [AW-1:0]    cmd_ra_i,
  input  logic [AW-1:0]    cmd_rb_i,
  input  logic [AW-1:0]    cmd_rc_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             done_valid_o,
  output logic [WIDTH-1:0] done_result_o,
  output logic             done_carry_o,
  output logic             done_err_o
);

`ifdef REG_SEQ_R0_ZERO_EN
  localparam bit R0Zero = 1'b1;
`else
  localparam bit R0Zero = 1'b0;
`endif

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpOr   = 4'd3;
  localparam logic [3:0] OpShl  = 4'd4;
  localparam logic [3:0] OpShr  = 4'd5;
  localparam logic [3:0] OpShra = 4'd6;
  localparam logic [3:0] OpNeg  = 4'd7;
  localparam logic [3:0] OpNot  = 4'd8;
  localparam logic [3:0] OpMov  = 4'd9;

  typedef enum logic [1:0] {StIdle, StLoadY, StExec, StWrite} state_e;

  state_e            state_q, state_d;
  logic [3:0]        op_q;
  logic [AW-1:0]     ra_q, rb_q, rc_q;
  logic [WIDTH-1:0]  y_q, z_q;
  logic              carry_q;
  logic [WIDTH-1:0]  regs_q [NREGS];
  logic [WIDTH-1:0]  bus;
  logic [WIDTH-1:0]  alu_res;
  logic              alu_carry;
  logic [WIDTH:0]    sum, diff;
  logic              op_err;
  logic              accept;

  function automatic logic [WIDTH-1:0] rf_read(input logic [AW-1:0] addr);
    if (R0Zero && addr == '0) return '0;
    return regs_q[addr];
  endfunction

  assign accept = cmd_valid_i && cmd_ready_o;
  assign op_err = op_q > OpMov;
  assign rd_data_o = rf_read(rd_addr_i);

  always_ff @(posedge clock_i or negedge clear_ni) begin
    if (!clear_ni) state_q <= StIdle;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StLoadY;
      StLoadY: state_d = StExec;
      StExec:  state_d = StWrite;
      StWrite: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cmd_ready_o   = (state_q == StIdle);
    done_valid_o  = (state_q == StWrite);
    done_err_o    = (state_q == StWrite) && op_err;
    done_carry_o  = (state_q == StWrite) && carry_q;
    done_result_o = z_q;
  end

  always_comb begin
    bus = '0;
    unique case (state_q)
      StLoadY: bus = rf_read(rb_q);
      StExec:  bus = rf_read(rc_q);
      StWrite: bus = z_q;
      default: bus = '0;
    endcase
  end

  always_comb begin
    sum       = {1'b0, y_q} + {1'b0, bus};
    diff      = {1'b0, y_q} - {1'b0, bus};
    alu_res   = z_q;
    alu_carry = 1'b0;
    case (op_q)
      OpAdd:  begin alu_res = sum[WIDTH-1:0];  alu_carry = sum[WIDTH];  end
      OpSub:  begin alu_res = diff[WIDTH-1:0]; alu_carry = diff[WIDTH]; end
      OpAnd:  alu_res = y_q & bus;
      OpOr:   alu_res = y_q | bus;
      OpShl:  alu_res = y_q << bus[SW-1:0];
      OpShr:  alu_res = y_q >> bus[SW-1:0];
      OpShra: alu_res = $signed(y_q) >>> bus[SW-1:0];
      OpNeg:  alu_res = '0 - bus;
      OpNot:  alu_res = ~bus;
      OpMov:  alu_res = bus;
      default: begin alu_res = z_q; alu_carry = 1'b0; end
    endcase
  end

  always_ff @(posedge clock_i or negedge clear_ni) begin
    if (!clear_ni) begin
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
      y_q     <= '0;
      z_q     <= '0;
      carry_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= cmd_op_i;
        ra_q <= cmd_ra_i;
        rb_q <= cmd_rb_i;
        rc_q <= cmd_rc_i;
      end
      if (state_q == StLoadY) y_q <= bus;
      if (state_q == StExec) begin
        z_q     <= alu_res;
        carry_q <= alu_carry;
      end
    end
  end

  // The sequencer write is issued last so it wins a same-address collision.
  always_ff @(posedge clock_i or negedge clear_ni) begin
    if (!clear_ni) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      if (wr_en_i && !(R0Zero && wr_addr_i == '0)) regs_q[wr_addr_i] <= wr_data_i;
      if (state_q == StWrite && !op_err && !(R0Zero && ra_q == '0)) regs_q[ra_q] <= z_q;
    end
  end

endmodule

// File: tb/tb_reg_bus_sequencer.sv
// Bench for reg_bus_sequencer: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model.
module tb_reg_bus_sequencer;
  localparam int W = 32;
  localparam int N = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          clear_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [3:0]    cmd_op = '0;
  logic [AW-1:0] cmd_ra = '0, cmd_rb = '0, cmd_rc = '0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [W-1:0]  rd_data;
  logic          done_valid, done_carry, done_err;
  logic [W-1:0]  done_result;

  reg_bus_sequencer #(.WIDTH(W), .NREGS(N)) dut (
    .clock_i(clk), .clear_ni(clear_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_ra_i(cmd_ra), .cmd_rb_i(cmd_rb), .cmd_rc_i(cmd_rc),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .done_valid_o(done_valid), .done_result_o(done_result),
    .done_carry_o(done_carry), .done_err_o(done_err)
  );

  always #5 clk = ~clk;

`ifdef REG_SEQ_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  // Model: register array plus "cycles since accept" for the command in flight.
  logic [W-1:0]  m_r [N];
  logic [W-1:0]  m_y, m_z;
  logic          m_c;
  int            m_age;
  logic [3:0]    m_op;
  logic [AW-1:0] m_ra, m_rb, m_rc;

  int            dones = 0;
  logic [W-1:0]  last_res;
  logic          last_c, last_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] m_read(input logic [AW-1:0] a);
    if (R0Z && a == 0) return '0;
    return m_r[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_r[i] = '0;
    m_y = '0; m_z = '0; m_c = 1'b0; m_age = 0; m_op = '0;
    m_ra = '0; m_rb = '0; m_rc = '0;
  endtask

  task automatic model_step();
    int old_age;
    logic [W-1:0] b;
    longint s;
    old_age = m_age;
    case (m_age)
      0: if (cmd_valid) begin
        m_op = cmd_op; m_ra = cmd_ra; m_rb = cmd_rb; m_rc = cmd_rc; m_age = 1;
      end
      1: begin m_y = m_read(m_rb); m_age = 2; end
      2: begin
        b = m_read(m_rc);
        m_age = 3;
        if (m_op < 10) m_c = 1'b0;
        case (m_op)
          0: begin s = longint'(m_y) + longint'(b); m_z = s[31:0]; m_c = s[32]; end
          1: begin m_z = m_y - b; m_c = (m_y < b); end
          2: m_z = m_y & b;
          3: m_z = m_y | b;
          4: m_z = m_y << b[4:0];
          5: m_z = m_y >> b[4:0];
          6: m_z = $signed(m_y) >>> b[4:0];
          7: m_z = 0 - b;
          8: m_z = ~b;
          9: m_z = b;
          default: m_c = 1'b0;
        endcase
      end
      default: m_age = 0;
    endcase
    if (wr_en && !(R0Z && wr_addr == 0)) m_r[wr_addr] = wr_data;
    if (old_age == 3 && m_op < 10 && !(R0Z && m_ra == 0)) m_r[m_ra] = m_z;
  endtask

  task automatic compare();
    chk("cmd_ready", cmd_ready, m_age == 0);
    chk("done_valid", done_valid, m_age == 3);
    chk("done_carry", done_carry, (m_age == 3) && m_c);
    chk("done_err", done_err, (m_age == 3) && (m_op >= 10));
    if (m_age == 3) chk("done_result", done_result, m_z);
    if (done_valid) begin
      dones++; last_res = done_result; last_c = done_carry; last_err = done_err;
    end
    rd_addr = AW'($urandom_range(0, N - 1));
    #1;
    chk("rd_data", rd_data, m_read(rd_addr));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    clear_n = 1'b0;
    model_reset();
    #1;
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_done", done_valid, 1'b0);
    @(negedge clk);
    @(negedge clk);
    clear_n = 1'b1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic run_cmd(input logic [3:0] op, input logic [AW-1:0] ra, rb, rc);
    int d0;
    d0 = dones;
    cmd_valid = 1'b1; cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rc = rc;
    tick();
    cmd_valid = 1'b0;
    repeat (3) tick();
    chk("one_done_pulse", dones - d0, 1);
  endtask

  task automatic peek(input string name, input logic [AW-1:0] a, input logic [W-1:0] exp);
    rd_addr = a;
    #1;
    chk(name, rd_data, exp);
  endtask

  int low_cnt;

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();
    peek("reset_r5", 4'd5, 32'h0);

    // ADD R3 = R1 + R2
    wr(4'd1, 32'd5);
    wr(4'd2, 32'd7);
    run_cmd(4'd0, 4'd3, 4'd1, 4'd2);
    chk("add_result", last_res, 32'd12);
    chk("add_carry", last_c, 1'b0);
    chk("model_add", m_z, 32'd12);
    peek("add_r3", 4'd3, 32'd12);

    // SUB with borrow
    wr(4'd1, 32'h3);
    wr(4'd2, 32'h5);
    run_cmd(4'd1, 4'd4, 4'd1, 4'd2);
    chk("sub_result", last_res, 32'hFFFF_FFFE);
    chk("sub_borrow", last_c, 1'b1);
    peek("sub_r4", 4'd4, 32'hFFFF_FFFE);

    // Shifts
    wr(4'd1, 32'h8000_0000);
    wr(4'd2, 32'd4);
    run_cmd(4'd6, 4'd5, 4'd1, 4'd2);
    chk("shra_result", last_res, 32'hF800_0000);
    peek("shra_r5", 4'd5, 32'hF800_0000);
    wr(4'd2, 32'd33);
    run_cmd(4'd4, 4'd5, 4'd1, 4'd2);
    chk("shl_result", last_res, 32'h0);
    wr(4'd2, 32'd4);
    run_cmd(4'd5, 4'd5, 4'd1, 4'd2);
    chk("shr_result", last_res, 32'h0800_0000);

    // Illegal op with cmd_valid held high
    cmd_valid = 1'b1; cmd_op = 4'd12; cmd_ra = 4'd7; cmd_rb = 4'd1; cmd_rc = 4'd2;
    low_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (!cmd_ready) low_cnt++;
    end
    chk("err_ready_low_cycles", low_cnt, 3);
    chk("err_flag", last_err, 1'b1);
    chk("err_result", last_res, 32'h0800_0000);
    tick();
    chk("err_next_accept", cmd_ready, 1'b0);
    cmd_valid = 1'b0;
    repeat (3) tick();
    peek("err_r7_unchanged", 4'd7, 32'h0);

    // Reset during EXEC aborts
    wr(4'd6, 32'h0);
    cmd_valid = 1'b1; cmd_op = 4'd0; cmd_ra = 4'd6; cmd_rb = 4'd1; cmd_rc = 4'd2;
    tick();
    cmd_valid = 1'b0;
    tick();
    low_cnt = dones;
    do_reset();
    chk("abort_no_done", dones - low_cnt, 0);
    peek("abort_r6", 4'd6, 32'h0);

    // R0 handling
    wr(4'd0, 32'd9);
    run_cmd(4'd9, 4'd1, 4'd3, 4'd0);
    peek("mov_r0_to_r1", 4'd1, R0Z ? 32'd0 : 32'd9);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      logic [W-1:0] d;
      case ($urandom_range(0, 4))
        0: d = 32'h0;
        1: d = 32'hFFFF_FFFF;
        2: d = 32'h8000_0000 | $urandom_range(0, 63);
        default: d = $urandom;
      endcase
      cmd_valid = ($urandom_range(0, 1) == 1);
      cmd_op    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                              : 4'($urandom_range(0, 9));
      cmd_ra    = AW'($urandom_range(0, N - 1));
      cmd_rb    = AW'($urandom_range(0, N - 1));
      cmd_rc    = AW'($urandom_range(0, N - 1));
      wr_en     = ($urandom_range(0, 9) < 3);
      wr_addr   = AW'($urandom_range(0, N - 1));
      wr_data   = d;
      if ($urandom_range(0, 299) == 0) do_reset();
      else tick();
    end
    cmd_valid = 1'b0;
    wr_en = 1'b0;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
